fifo_stream_reader: RTL and testbench

Pop-side adapter for the common `Fifo`. It drains a show-ahead FIFO (empty/rdata/pop) and presents its entries to a downstream consumer as a registered val/rdy stream. A 2-entry output buffer (output register plus skid slot) keeps full throughput. There is no combinational path from `ostream_rdy` to `fifo_pop` or from `fifo_rdata` to `ostream_msg`. It sits between any producer-side FIFO and a val/rdy consumer, alongside `Fifo` in `hw/common`.

---
 rtl/fifo_stream_reader_if.sv | 32 +++
 rtl/fifo_stream_reader.sv | 107 ++++++++++
 tb/tb_fifo_stream_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO pop-side and val/rdy stream signals of fifo_stream_reader
//
// Purpose: bundles the show-ahead FIFO read port and the downstream val/rdy
// stream so the reader and its surroundings connect through one handle.
// Ports:
//   fifo_empty  FIFO empty flag                    (into reader)
//   fifo_rdata  FIFO head entry, valid when !empty (into reader)
//   fifo_pop    pop strobe                         (from reader)
//   ostream_val output valid, registered           (from reader)
//   ostream_rdy consumer ready                     (into reader)
//   ostream_msg output data, registered            (from reader)
// Modports: master = reader side, slave = FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter type t_entry = logic [31:0]
);
  logic   fifo_empty;
  t_entry fifo_rdata;
  logic   fifo_pop;
  logic   ostream_val;
  logic   ostream_rdy;
  t_entry ostream_msg;

  modport master (
    input  fifo_empty, fifo_rdata, ostream_rdy,
    output fifo_pop, ostream_val, ostream_msg
  );

  modport slave (
    output fifo_empty, fifo_rdata, ostream_rdy,
    input  fifo_pop, ostream_val, ostream_msg
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a show-ahead FIFO into a registered val/rdy stream
//
// Purpose: pops the FIFO into a 2-entry buffer (output register + skid slot)
// so the stream runs at one entry per cycle while neither ostream_rdy reaches
// fifo_pop nor fifo_rdata reaches ostream_msg combinationally.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   flush  synchronous discard of buffered entries
//   count  completed output transfers, modulo 2^p_count_bits
//   bus    fifo_stream_reader_if.master (FIFO read port + output stream)
module fifo_stream_reader #(
  parameter type t_entry      = logic [31:0],
  parameter int  p_count_bits = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  output logic [p_count_bits-1:0] count,
  fifo_stream_reader_if.master    bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                    occ_q, occ_d;
  t_entry                  out_q, out_d;
  t_entry                  skid_q, skid_d;
  logic [p_count_bits-1:0] count_q, count_d;

  logic enq;
  logic deq;
  logic val;

  // Pop decision uses only registered occupancy plus FIFO/flush/reset inputs.
  assign enq = rst_n & ~bus.fifo_empty & (occ_q != OCC_TWO) & ~flush;
  assign val = (occ_q != OCC_EMPTY);
  assign deq = val & bus.ostream_rdy;

  assign bus.fifo_pop    = enq;
  assign bus.ostream_val = val;
  assign bus.ostream_msg = out_q;
  assign count           = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= OCC_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    occ_d   = occ_q;
    out_d   = out_q;
    skid_d  = skid_q;
    count_d = count_q;

    case (occ_q)
      OCC_EMPTY: begin
        if (enq) begin
          out_d = bus.fifo_rdata;
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (enq && deq) begin
          // Output register frees up this cycle, so the new entry goes straight there.
          out_d = bus.fifo_rdata;
        end else if (enq) begin
          skid_d = bus.fifo_rdata;
          occ_d  = OCC_TWO;
        end else if (deq) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (deq) begin
          out_d = skid_q;
          occ_d = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase

    if (deq) begin
      count_d = count_q + 1'b1;
    end

    // A concurrent handshake still completes and counts; everything left is
    // dropped and the output register keeps its last value.
    if (flush) begin
      occ_d = OCC_EMPTY;
      out_d = out_q;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int CB = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [CB-1:0] count;

  fifo_stream_reader_if #(.t_entry(logic [31:0])) bus ();

  fifo_stream_reader #(
    .t_entry      (logic [31:0]),
    .p_count_bits (CB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_bad;
  int          n_pops;
  int          count_m;
  logic [31:0] last_msg;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  // Samples on the falling edge, applies the rising edge, then refreshes the FIFO head.
  task automatic tick();
    logic        pop_s, val_s, rdy_s, flush_s;
    logic [31:0] msg_s;
    @(negedge clk);
    pop_s   = bus.fifo_pop;
    val_s   = bus.ostream_val;
    rdy_s   = bus.ostream_rdy;
    msg_s   = bus.ostream_msg;
    flush_s = flush;
    if (rst_n) begin
      chk("pop", {31'b0, pop_s},
          {31'b0, (fifo_q.size() != 0) && (exp_q.size() < 2) && !flush_s});
      chk("val", {31'b0, val_s}, {31'b0, exp_q.size() != 0});
      chk("count", {28'b0, count}, count_m);
      if (val_s && rdy_s) begin
        if (exp_q.size() == 0) chk("underflow", 32'd1, 32'd0);
        else chk("msg", msg_s, exp_q.pop_front());
        count_m = (count_m + 1) % (1 << CB);
      end else if (!val_s) begin
        chk("hold", msg_s, last_msg);
      end
      last_msg = msg_s;
      if (flush_s) exp_q.delete();
      if (pop_s) begin
        n_pops++;
        if (fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
      end
    end else begin
      chk("rst_pop", {31'b0, pop_s}, 32'd0);
      chk("rst_val", {31'b0, val_s}, 32'd0);
      chk("rst_cnt", {28'b0, count}, 32'd0);
      exp_q.delete();
      count_m  = 0;
      last_msg = 32'h0;
    end
    @(posedge clk);
    #1;
    drive_fifo();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ostream_rdy = 1'b0;
    fifo_q.delete();
    drive_fifo();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    chk("drain_empty", fifo_q.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_pops = 0; count_m = 0; last_msg = 32'h0;
    flush = 1'b0;
    bus.ostream_rdy = 1'b1;
    rst_n = 1'b0;
    push(32'h12345678);
    #1;
    chk("reset_pop", {31'b0, bus.fifo_pop}, 32'd0);
    chk("reset_val", {31'b0, bus.ostream_val}, 32'd0);
    chk("reset_msg", bus.ostream_msg, 32'h0);
    chk("reset_cnt", {28'b0, count}, 32'd0);
    tick();

    // Single entry
    do_reset();
    bus.ostream_rdy = 1'b1;
    push(32'hdeadbeef);
    tick();
    chk("single_val1", {31'b0, bus.ostream_val}, 32'd1);
    chk("single_msg", bus.ostream_msg, 32'hdeadbeef);
    tick();
    chk("single_val0", {31'b0, bus.ostream_val}, 32'd0);
    chk("single_cnt", {28'b0, count}, 32'd1);

    // Streaming 1..8
    do_reset();
    bus.ostream_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) push(i);
    for (int i = 0; i < 9; i++) tick();
    chk("stream_cnt", {28'b0, count}, 32'd8);
    chk("stream_val0", {31'b0, bus.ostream_val}, 32'd0);

    // Backpressure
    do_reset();
    bus.ostream_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) push(i);
    n_pops = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_pops", n_pops, 32'd2);
    chk("bp_msg", bus.ostream_msg, 32'd1);
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_cnt", {28'b0, count}, 32'd4);

    // Flush with two buffered entries
    do_reset();
    bus.ostream_rdy = 1'b0;
    push(32'd7); push(32'd8); push(32'd9);
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_val", {31'b0, bus.ostream_val}, 32'd0);
    chk("flush_msg", bus.ostream_msg, 32'd7);
    chk("flush_cnt", {28'b0, count}, 32'd0);
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("flush_after", {28'b0, count}, 32'd1);

    // Flush while a handshake is completing with occupancy two
    push(32'd20); push(32'd21);
    bus.ostream_rdy = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.ostream_rdy = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_deq_cnt", {28'b0, count}, 32'd2);
    chk("flush_deq_msg", bus.ostream_msg, 32'd20);

    // Counter wrap
    do_reset();
    bus.ostream_rdy = 1'b1;
    for (int i = 1; i <= 17; i++) push(32'h100 + i);
    for (int i = 0; i < 18; i++) tick();
    chk("wrap_cnt", {28'b0, count}, 32'd1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bus.ostream_rdy = $urandom_range(0, 1);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) != 0) push($urandom);
      tick();
    end
    flush = 1'b0;
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) push(32'h200 + i);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_val", {31'b0, bus.ostream_val}, 32'd0);
    chk("areset_cnt", {28'b0, count}, 32'd0);
    chk("areset_pop", {31'b0, bus.fifo_pop}, 32'd0);
    tick();
    rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
